// File: rtl/sm_seq_monitor.sv
// sm_seq_monitor: watches a 4-state sequencer (y, control) and checks every
// transition against the legal graph 0->1, 1->2 (ctl=0), 1->3 (ctl=1),
// 2->3, 3->0. It counts loops, long loops, short loops and illegal
// transitions with saturating counters.
//
// Optional: define SM_SEQ_MONITOR_ERR_CAPTURE_EN to add capture registers
// that hold the first illegal transition after reset or clear.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   control, y      sequencer control bit and state output, sampled every clk
//   clear           synchronous clear of the counters, err_flag and captures
//   in_sync         high while tracking
//   err_pulse       one-cycle pulse per illegal transition
//   err_flag        sticky error flag
//   loop_cnt        legal 3->0 count
//   long_cnt        legal 1->2 count
//   short_cnt       legal 1->3 count
//   err_cnt         illegal transition count
//   err_prev_y/err_prev_ctl/err_y   first illegal transition (optional)
module sm_seq_monitor #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 control,
  input  logic [1:0]           y,
  input  logic                 clear,
  output logic                 in_sync,
  output logic                 err_pulse,
  output logic                 err_flag,
  output logic [CNT_WIDTH-1:0] loop_cnt,
  output logic [CNT_WIDTH-1:0] long_cnt,
  output logic [CNT_WIDTH-1:0] short_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
  ,
  output logic [1:0]           err_prev_y,
  output logic [0:0]           err_prev_ctl,
  output logic [1:0]           err_y
`endif
);

  typedef enum logic {SYNC, TRACK} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [1:0]           prev_y_q;
  logic                 prev_ctl_q;
  logic                 err_pulse_q, err_pulse_d;
  logic                 err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0] loop_q, loop_d;
  logic [CNT_WIDTH-1:0] long_q, long_d;
  logic [CNT_WIDTH-1:0] short_q, short_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic                 legal;
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
  logic [1:0]           cap_prev_y_q, cap_prev_y_d;
  logic                 cap_prev_ctl_q, cap_prev_ctl_d;
  logic [1:0]           cap_y_q, cap_y_d;
`endif

  // Legal successor of the previous sample; ctl only matters leaving state 1.
  always_comb begin
    legal = 1'b0;
    case (prev_y_q)
      2'd0: legal = (y == 2'd1);
      2'd1: legal = (y == (prev_ctl_q ? 2'd3 : 2'd2));
      2'd2: legal = (y == 2'd3);
      2'd3: legal = (y == 2'd0);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    err_pulse_d = 1'b0;
    err_flag_d  = err_flag_q;
    loop_d      = loop_q;
    long_d      = long_q;
    short_d     = short_q;
    err_d       = err_q;
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
    cap_prev_y_d   = cap_prev_y_q;
    cap_prev_ctl_d = cap_prev_ctl_q;
    cap_y_d        = cap_y_q;
`endif
    case (state_q)
      SYNC: if (y == 2'd0) state_d = TRACK;
      TRACK: begin
        if (legal) begin
          if (prev_y_q == 2'd3 && loop_q != CNT_MAX) loop_d = loop_q + 1'b1;
          if (prev_y_q == 2'd1 && y == 2'd2 && long_q != CNT_MAX) long_d = long_q + 1'b1;
          if (prev_y_q == 2'd1 && y == 2'd3 && short_q != CNT_MAX) short_d = short_q + 1'b1;
        end else begin
          // The offending y is never reused for resync: SYNC needs a new edge.
          state_d     = SYNC;
          err_pulse_d = 1'b1;
          err_flag_d  = 1'b1;
          if (err_q != CNT_MAX) err_d = err_q + 1'b1;
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
          if (!err_flag_q) begin
            cap_prev_y_d   = prev_y_q;
            cap_prev_ctl_d = prev_ctl_q;
            cap_y_d        = y;
          end
`endif
        end
      end
      default: state_d = SYNC;
    endcase
    // clear overrides same-edge updates but leaves the FSM and pulse alone.
    if (clear) begin
      err_flag_d = 1'b0;
      loop_d     = '0;
      long_d     = '0;
      short_d    = '0;
      err_d      = '0;
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
      cap_prev_y_d   = '0;
      cap_prev_ctl_d = 1'b0;
      cap_y_d        = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      prev_y_q    <= '0;
      prev_ctl_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
      loop_q      <= '0;
      long_q      <= '0;
      short_q     <= '0;
      err_q       <= '0;
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
      cap_prev_y_q   <= '0;
      cap_prev_ctl_q <= 1'b0;
      cap_y_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prev_y_q    <= y;
      prev_ctl_q  <= control;
      err_pulse_q <= err_pulse_d;
      err_flag_q  <= err_flag_d;
      loop_q      <= loop_d;
      long_q      <= long_d;
      short_q     <= short_d;
      err_q       <= err_d;
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
      cap_prev_y_q   <= cap_prev_y_d;
      cap_prev_ctl_q <= cap_prev_ctl_d;
      cap_y_q        <= cap_y_d;
`endif
    end
  end

  assign in_sync   = (state_q == TRACK);
  assign err_pulse = err_pulse_q;
  assign err_flag  = err_flag_q;
  assign loop_cnt  = loop_q;
  assign long_cnt  = long_q;
  assign short_cnt = short_q;
  assign err_cnt   = err_q;
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
  assign err_prev_y   = cap_prev_y_q;
  assign err_prev_ctl = cap_prev_ctl_q;
  assign err_y        = cap_y_q;
`endif

endmodule

// File: tb/tb_sm_seq_monitor.sv
module tb_sm_seq_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic control = 1'b0;
  logic [1:0] y = 2'd0;
  logic clear = 1'b0;

  logic in_sync, err_pulse, err_flag;
  logic [15:0] loop_cnt, long_cnt, short_cnt, err_cnt;
  logic in_sync4, err_pulse4, err_flag4;
  logic [3:0] loop4, long4, short4, err4;
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
  logic [1:0] cpy, cy, cpy4, cy4;
  logic [0:0] cpc, cpc4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm_seq_monitor dut (
    .clk(clk), .reset(reset), .control(control), .y(y), .clear(clear),
    .in_sync(in_sync), .err_pulse(err_pulse), .err_flag(err_flag),
    .loop_cnt(loop_cnt), .long_cnt(long_cnt), .short_cnt(short_cnt), .err_cnt(err_cnt)
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
    , .err_prev_y(cpy), .err_prev_ctl(cpc), .err_y(cy)
`endif
  );

  sm_seq_monitor #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .control(control), .y(y), .clear(clear),
    .in_sync(in_sync4), .err_pulse(err_pulse4), .err_flag(err_flag4),
    .loop_cnt(loop4), .long_cnt(long4), .short_cnt(short4), .err_cnt(err4)
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
    , .err_prev_y(cpy4), .err_prev_ctl(cpc4), .err_y(cy4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, let the edge happen, then look 1 ns later.
  task automatic step(input logic [1:0] yv, input logic cv);
    y = yv;
    control = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2'd0, 1'b0);
    step(2'd0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic cnts(input string tag, input int lp, input int lg, input int sh, input int er);
    chk({tag, ".loop"}, loop_cnt, lp);
    chk({tag, ".long"}, long_cnt, lg);
    chk({tag, ".short"}, short_cnt, sh);
    chk({tag, ".err"}, err_cnt, er);
  endtask

  initial begin
    // Reset state
    #1;
    do_reset();
    chk("rst.in_sync", in_sync, 0);
    chk("rst.err_pulse", err_pulse, 0);
    chk("rst.err_flag", err_flag, 0);
    cnts("rst", 0, 0, 0, 0);
    // y nonzero in SYNC: no tracking
    step(2'd2, 1'b0);
    chk("sync.stay", in_sync, 0);

    // 1: long loop
    step(2'd0, 1'b0);
    chk("t1.in_sync", in_sync, 1);
    step(2'd1, 1'b0);
    step(2'd2, 1'b0);
    chk("t1.long_early", long_cnt, 1);
    step(2'd3, 1'b0);
    step(2'd0, 1'b0);
    cnts("t1", 1, 1, 0, 0);
    chk("t1.err_flag", err_flag, 0);

    // 2: short loop
    do_reset();
    step(2'd0, 1'b0);
    step(2'd1, 1'b1);
    step(2'd3, 1'b0);
    step(2'd0, 1'b0);
    cnts("t2", 1, 0, 1, 0);
    chk("t2.in_sync", in_sync, 1);

    // 3: error (1 with ctl=1 followed by 2) and recovery
    step(2'd1, 1'b1);
    chk("t3.pre_pulse", err_pulse, 0);
    step(2'd2, 1'b0);
    chk("t3.err_pulse", err_pulse, 1);
    chk("t3.err_cnt", err_cnt, 1);
    chk("t3.err_flag", err_flag, 1);
    chk("t3.in_sync", in_sync, 0);
    chk("t3.long_unchanged", long_cnt, 0);
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
    chk("t3.cap_prev_y", cpy, 1);
    chk("t3.cap_prev_ctl", cpc, 1);
    chk("t3.cap_y", cy, 2);
`endif
    step(2'd3, 1'b0);
    chk("t3.pulse_once", err_pulse, 0);
    chk("t3.still_sync", in_sync, 0);
    chk("t3.no_count", loop_cnt, 1);
    step(2'd0, 1'b0);
    chk("t3.resync", in_sync, 1);
    step(2'd1, 1'b0);
    chk("t3.no_more_err", err_cnt, 1);
    chk("t3.flag_sticky", err_flag, 1);
    // Second error must not overwrite the capture
    step(2'd1, 1'b0);
    chk("t3.err2_cnt", err_cnt, 2);
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
    chk("t3.cap_hold_y", cy, 2);
    chk("t3.cap_hold_prev", cpy, 1);
`endif

    // 4: saturation on the 4-bit instance
    do_reset();
    step(2'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(2'd1, 1'b0);
      step(2'd2, 1'b0);
      step(2'd3, 1'b0);
      step(2'd0, 1'b0);
    end
    chk("t4.loop4_sat", loop4, 15);
    chk("t4.long4_sat", long4, 15);
    chk("t4.loop16", loop_cnt, 20);
    chk("t4.long16", long_cnt, 20);
    chk("t4.err4", err4, 0);

    // 5: clear on a legal 3->0 with err_flag set
    step(2'd0, 1'b0);                // 0->0 illegal
    chk("t5.err_set", err_flag, 1);
    step(2'd0, 1'b0);                // resync
    step(2'd1, 1'b0);
    step(2'd2, 1'b0);
    step(2'd3, 1'b0);
    clear = 1'b1;
    step(2'd0, 1'b0);
    clear = 1'b0;
    chk("t5.loop_clr", loop_cnt, 0);
    chk("t5.err_flag_clr", err_flag, 0);
    chk("t5.err_cnt_clr", err_cnt, 0);
    chk("t5.in_sync", in_sync, 1);
    step(2'd1, 1'b0);
    chk("t5.in_sync2", in_sync, 1);
    // clear on the same edge as an error: pulse fires, FSM drops, counts stay 0
    clear = 1'b1;
    step(2'd1, 1'b0);
    clear = 1'b0;
    chk("t5b.pulse", err_pulse, 1);
    chk("t5b.in_sync", in_sync, 0);
    chk("t5b.err_cnt", err_cnt, 0);
    chk("t5b.err_flag", err_flag, 0);
`ifdef SM_SEQ_MONITOR_ERR_CAPTURE_EN
    chk("t5b.cap_y", cy, 0);
    chk("t5b.cap_prev_y", cpy, 0);
`endif

    // 6: reset mid-loop
    do_reset();
    step(2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(2'd1, 1'b0);
      step(2'd2, 1'b0);
      step(2'd3, 1'b0);
      step(2'd0, 1'b0);
    end
    step(2'd1, 1'b0);
    step(2'd2, 1'b0);
    chk("t6.loop5", loop_cnt, 5);
    reset = 1'b1;
    step(2'd3, 1'b0);
    reset = 1'b0;
    cnts("t6", 0, 0, 0, 0);
    chk("t6.in_sync", in_sync, 0);
    step(2'd3, 1'b0);
    chk("t6.no_err", err_cnt, 0);
    chk("t6.still_sync", in_sync, 0);
    step(2'd0, 1'b0);
    chk("t6.resync", in_sync, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm_seq_monitor.md
Name: sm_seq_monitor

Overview:
- Downstream consumer of the 4-state sequencer output `y[1:0]` and its `control` input.
- Tracks the sequencer cycle by cycle and checks every transition against the legal graph: 0->1, 1->2 (control=0), 1->3 (control=1), 2->3, 3->0.
- Counts completed loops, long loops (via state 2), short loops (skipping state 2) and illegal transitions, with saturating counters.
- Provides an in-sync indicator and an error flag for bring-up and debug.

Parameters:
- CNT_WIDTH, 16, width of every event counter; counters saturate at 2^CNT_WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- control  in  1  same control bit driven into the sequencer, sampled every clk.
- y  in  2  sequencer state output, sampled every clk.
- clear  in  1  synchronous clear of counters and err_flag; does not affect FSM.
- in_sync  out  1  high while FSM is in TRACK.
- err_pulse  out  1  one-cycle pulse per illegal transition detected.
- err_flag  out  1  sticky error indicator; cleared only by clear or reset.
- loop_cnt  out  CNT_WIDTH  count of legal 3->0 transitions.
- long_cnt  out  CNT_WIDTH  count of legal 1->2 transitions.
- short_cnt  out  CNT_WIDTH  count of legal 1->3 transitions.
- err_cnt  out  CNT_WIDTH  count of illegal transitions.

Behaviour:
- Reset:
  - FSM goes to SYNC; all counters 0; err_flag=0; err_pulse=0; in_sync=0; prev_y=0; prev_ctl=0.
  - Reset has priority over all other inputs.
  - Reset mid-operation aborts tracking immediately.
- Sampling:
  - Every clk edge registers prev_y<=y and prev_ctl<=control.
  - The checked transition is (prev_y, prev_ctl) -> current y.
- FSM states: SYNC and TRACK.
  - SYNC: no checking, no counting. Go to TRACK on an edge where y==0; otherwise stay in SYNC.
  - TRACK: check every edge.
    - Legal: prev_y=0 -> y=1; prev_y=1 and prev_ctl=0 -> y=2; prev_y=1 and prev_ctl=1 -> y=3; prev_y=2 -> y=3; prev_y=3 -> y=0.
    - Anything else is illegal, including a repeated state.
    - Illegal: err_cnt+1, err_flag<=1, err_pulse<=1 for exactly one cycle, FSM -> SYNC. The y value on the error edge is not used for resync; the earliest resync is the following edge with y==0.
- Counter events (TRACK only, legal transitions only):
  - 3->0 increments loop_cnt.
  - 1->2 increments long_cnt.
  - 1->3 increments short_cnt.
- Latency: counter and flag updates are registered and visible the cycle after the sampled edge. err_pulse is high the cycle after the offending sample.
- Saturation: each counter holds at all-ones; further events are ignored and do not wrap.
- clear:
  - Zeros all four counters and err_flag on the edge where it is high.
  - clear beats a same-edge increment or error set. The FSM still transitions to SYNC on that error, and err_pulse still fires.
- in_sync = (state==TRACK), registered.

Optional Feature:
- Macro: SM_SEQ_MONITOR_ERR_CAPTURE_EN.
- Defined: adds outputs err_prev_y[1:0], err_prev_ctl[0:0] and err_y[1:0].
  - These capture the first illegal transition after reset or clear.
  - They hold until clear or reset, which zero them.
  - Later errors do not overwrite them while err_flag=1.
- Not defined: the ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then y=0,1,2,3,0 with control=0 while y=1 -> in_sync=1 from the cycle after the first y=0; loop_cnt=1, long_cnt=1, short_cnt=0, err_cnt=0, err_flag=0.
2. Reset, then y=0,1,3,0 with control=1 while y=1 -> short_cnt=1, loop_cnt=1, long_cnt=0, err_cnt=0.
3. Error and recovery:
   - In TRACK, y=1 with control=1, then y=2 -> err_pulse high exactly one cycle, err_cnt=1, err_flag=1, in_sync=0.
   - Then y=3,0,1 -> in_sync returns to 1 after the y=0 edge; no further errors.
4. CNT_WIDTH=4, 20 full loops (0,1,2,3) -> loop_cnt=15 and long_cnt=15, no wrap.
5. clear asserted on the same edge as a legal 3->0 and with err_flag=1 -> loop_cnt=0, err_flag=0, in_sync unaffected.
6. Reset mid-loop (y=2, loop_cnt=5), then y=3 -> all counters 0, in_sync=0, no error counted. With SM_SEQ_MONITOR_ERR_CAPTURE_EN defined, scenario 3 captures err_prev_y=1, err_prev_ctl=1, err_y=2.
